// File: rtl/pulsegen_multilane_if.sv
// Bundle for the pulse generator: AXI-Lite register port, trigger sink and sample source.
interface pulsegen_multilane_if #(
    parameter int DATA_W = 8
);
    logic [3:0]        awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [3:0]        araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic              s_avst_valid;
    logic [7:0]        s_avst_data;
    logic              s_avst_ready;
    logic [DATA_W-1:0] m_avst_data;
    logic              m_avst_valid;
    logic              m_avst_ready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
        input  s_avst_valid, s_avst_data, m_avst_ready,
        output s_avst_ready, m_avst_data, m_avst_valid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
        output s_avst_valid, s_avst_data, m_avst_ready,
        input  s_avst_ready, m_avst_data, m_avst_valid
    );
endinterface

// File: rtl/pulsegen_multilane.sv
// Burst square-wave stimulus source for the TDC chain: AXI-Lite configured, AV-ST output
// with backpressure that freezes the waveform in-stream.
//
// burst state | meaning
// IDLE        | no burst pending; waits for a nonzero SAMPLE_COUNT write
// ARMED       | count loaded; waits for ip-sync trigger (or none if IPSYNC_EN = 0)
// WAIT_EDGE   | waits for a rising event of the wave
// RUN         | emits one sample per advance; cnt counts down to 1
// DONE        | one cycle: flag DONE, count burst, re-arm when continuous
module pulsegen_multilane #(
    parameter int          DATA_W          = 8,
    parameter int          CNT_W           = 32,
    parameter int          PIPELINE_OUTPUT = 2,
    parameter logic [15:0] HP_RESET        = 16'd2
) (
    input logic                 clk,
    input logic                 rst,
    pulsegen_multilane_if.slave bus
);
    localparam logic [1:0] W_RESET = 2'd0, W_IDLE = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3;
    localparam logic [1:0] R_RESET = 2'd0, R_IDLE = 2'd1, R_DATA = 2'd2;
    localparam logic [2:0] B_IDLE = 3'd0, B_ARMED = 3'd1, B_WAIT_EDGE = 3'd2,
                           B_RUN = 3'd3, B_DONE = 3'd4;

    logic [1:0]        wstate, rstate, awaddr_q;
    logic [2:0]        bstate;
    logic [CNT_W-1:0]  sample_count, cnt, sc_new;
    logic              ipsync_en, cont, done_flag, arm_req, trig, s_ready;
    logic [DATA_W-1:0] lane_mask;
    logic [15:0]       half_period, hp_new, hp_eff, phase, bursts;
    logic              level, adv, wrap, rise, wr_fire, sc_wr, abort, done_set, done_clr;
    logic [31:0]       ctrl_word, ctrl_new, rd_word, rdata_q;
    logic [PIPELINE_OUTPUT-1:0] pipe_valid;
    logic [DATA_W-1:0]          pipe_data [PIPELINE_OUTPUT];
    logic              unused_bits;

    function automatic logic [31:0] wr_merge(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) res[8*i +: 8] = s[i] ? d[8*i +: 8] : old[8*i +: 8];
        return res;
    endfunction

    always_comb begin
        ctrl_word               = '0;
        ctrl_word[0]            = ipsync_en;
        ctrl_word[1]            = cont;
        ctrl_word[8 +: DATA_W]  = lane_mask;
    end

    assign ctrl_new = wr_merge(ctrl_word, bus.wdata, bus.wstrb);
    assign sc_new   = CNT_W'(wr_merge(32'(sample_count), bus.wdata, bus.wstrb));
    assign hp_new   = 16'(wr_merge({16'h0, half_period}, bus.wdata, bus.wstrb));
    assign unused_bits = ^{bus.awprot, bus.arprot, bus.awaddr[1:0], bus.araddr[1:0],
                           bus.s_avst_data[7:1], ctrl_new[31:8+DATA_W], ctrl_new[7:2]};

    assign wr_fire  = (wstate == W_DATA) && bus.wvalid;
    assign sc_wr    = wr_fire && (awaddr_q == 2'd0);
    assign abort    = sc_wr && (sc_new == '0);
    assign done_clr = wr_fire && (awaddr_q == 2'd3) && bus.wstrb[0] && bus.wdata[1];

    assign adv      = ~pipe_valid[PIPELINE_OUTPUT-1] | bus.m_avst_ready;
    assign done_set = adv && (bstate == B_DONE);
    assign hp_eff   = (half_period == 16'd0) ? 16'd1 : half_period;
    assign wrap     = (phase >= hp_eff - 16'd1);
    assign rise     = wrap && !level;

    always_comb begin
        case (bus.araddr[3:2])
            2'd0:    rd_word = 32'(sample_count);
            2'd1:    rd_word = ctrl_word;
            2'd2:    rd_word = {16'h0, half_period};
            2'd3:    rd_word = {bursts, 14'h0, done_flag, bstate != B_IDLE};
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate   <= W_RESET;
            awaddr_q <= 2'd0;
        end else begin
            case (wstate)
                W_RESET: wstate <= W_IDLE;
                W_IDLE: if (bus.awvalid) begin
                    awaddr_q <= bus.awaddr[3:2];
                    wstate   <= W_DATA;
                end
                W_DATA:  if (bus.wvalid) wstate <= W_RESP;
                W_RESP:  if (bus.bready) wstate <= W_IDLE;
                default: wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate  <= R_RESET;
            rdata_q <= '0;
        end else begin
            case (rstate)
                R_RESET: rstate <= R_IDLE;
                R_IDLE: if (bus.arvalid) begin
                    rdata_q <= rd_word;
                    rstate  <= R_DATA;
                end
                R_DATA:  if (bus.rready) rstate <= R_IDLE;
                default: rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_count <= '0;
            ipsync_en    <= 1'b0;
            cont         <= 1'b0;
            lane_mask    <= '1;
            half_period  <= HP_RESET;
        end else if (wr_fire) begin
            case (awaddr_q)
                2'd0: sample_count <= sc_new;
                2'd1: begin
                    ipsync_en <= ctrl_new[0];
                    cont      <= ctrl_new[1];
                    lane_mask <= ctrl_new[8 +: DATA_W];
                end
                2'd2:    half_period <= hp_new;
                default: ;
            endcase
        end
    end

    // set beats clear when DONE lands on the same cycle as a W1C
    always_ff @(posedge clk) begin
        if (rst) begin
            done_flag <= 1'b0;
            bursts    <= 16'h0;
        end else if (done_set) begin
            done_flag <= 1'b1;
            bursts    <= bursts + 16'd1;
        end else if (done_clr) begin
            done_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase   <= 16'h0;
            level   <= 1'b0;
            trig    <= 1'b0;
            s_ready <= 1'b0;
        end else begin
            trig    <= bus.s_avst_valid & bus.s_avst_data[0];
            s_ready <= 1'b1;
            if (adv) begin
                if (wrap) begin
                    phase <= 16'h0;
                    level <= ~level;
                end else begin
                    phase <= phase + 16'd1;
                end
            end
        end
    end

    // arm_req makes IDLE load only on a fresh nonzero write, so one-shot bursts stay one-shot
    always_ff @(posedge clk) begin
        if (rst) begin
            bstate  <= B_IDLE;
            cnt     <= '0;
            arm_req <= 1'b0;
        end else begin
            if (abort) begin
                bstate <= B_IDLE;
            end else if (adv) begin
                case (bstate)
                    B_IDLE: if (arm_req && sample_count != '0) begin
                        cnt     <= sample_count;
                        arm_req <= 1'b0;
                        bstate  <= B_ARMED;
                    end
                    B_ARMED:     if (!ipsync_en || trig) bstate <= B_WAIT_EDGE;
                    B_WAIT_EDGE: if (rise) bstate <= B_RUN;
                    B_RUN: begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt <= CNT_W'(1)) bstate <= B_DONE;
                    end
                    B_DONE: if (cont && sample_count != '0) begin
                        cnt    <= sample_count;
                        bstate <= B_ARMED;
                    end else begin
                        bstate <= B_IDLE;
                    end
                    default: bstate <= B_IDLE;
                endcase
            end
            if (sc_wr) arm_req <= (sc_new != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= '0;
            for (int i = 0; i < PIPELINE_OUTPUT; i++) pipe_data[i] <= '0;
        end else if (adv) begin
            pipe_valid[0] <= (bstate == B_RUN);
            pipe_data[0]  <= (bstate == B_RUN) ? ({DATA_W{level}} & lane_mask) : '0;
            for (int i = 1; i < PIPELINE_OUTPUT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    assign bus.awready      = (wstate == W_IDLE);
    assign bus.wready       = (wstate == W_DATA);
    assign bus.bvalid       = (wstate == W_RESP);
    assign bus.bresp        = 2'b00;
    assign bus.arready      = (rstate == R_IDLE);
    assign bus.rvalid       = (rstate == R_DATA);
    assign bus.rdata        = rdata_q;
    assign bus.rresp        = 2'b00;
    assign bus.s_avst_ready = s_ready;
    assign bus.m_avst_valid = pipe_valid[PIPELINE_OUTPUT-1];
    assign bus.m_avst_data  = pipe_data[PIPELINE_OUTPUT-1];
endmodule
